vcve2_rf_wb_arbiter: RTL

Writer side of the flip-flop register file's single write port. Collects write-back requests from two producers and drives one registered write per cycle into the register file (waddr/wdata/we):
- EX: one result per cycle, never stalls upstream for long.
- LSU: load data, buffered in a small FIFO.

Also keeps a per-register pending-load scoreboard, so decode can stall reads of registers with loads still outstanding.

---
 rtl/vcve2_rf_wb_arbiter_if.sv | 78 +++++++
 rtl/vcve2_rf_wb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vcve2_rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vcve2_rf_wb_arbiter_if
//
// Purpose:
//   Bundles the write-back arbiter's request, scoreboard, read-lookup and
//   register-file write signals. Signal names keep the arbiter's own view:
//   *_i are driven into the arbiter and *_o are driven by it.
//
// Modports:
//   master : producers / decode / register file side (drives *_i, reads *_o)
//   slave  : the arbiter itself (reads *_i, drives *_o)
//
// Signals:
//   ex_valid_i/ex_addr_i/ex_data_i, ex_ready_o         EX write request
//   lsu_valid_i/lsu_addr_i/lsu_data_i, lsu_ready_o     LSU load data
//   sb_set_i/sb_set_addr_i                             load issued, mark pending
//   raddr_a_i/raddr_b_i, busy_a_o/busy_b_o             decode pending lookup
//   waddr_a_o/wdata_a_o/we_a_o                         register-file write port
//
// Optional feature (macro VCVE2_WB_FWD_EN):
//   adds fwd_a_o/fwd_b_o write-stage forwarding hints for decode.
// ---------------------------------------------------------------------------
interface vcve2_rf_wb_arbiter_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 ex_valid_i;
    logic [4:0]           ex_addr_i;
    logic [DataWidth-1:0] ex_data_i;
    logic                 ex_ready_o;

    logic                 lsu_valid_i;
    logic [4:0]           lsu_addr_i;
    logic [DataWidth-1:0] lsu_data_i;
    logic                 lsu_ready_o;

    logic                 sb_set_i;
    logic [4:0]           sb_set_addr_i;

    logic [4:0]           raddr_a_i;
    logic [4:0]           raddr_b_i;
    logic                 busy_a_o;
    logic                 busy_b_o;

    logic [4:0]           waddr_a_o;
    logic [DataWidth-1:0] wdata_a_o;
    logic                 we_a_o;

`ifdef VCVE2_WB_FWD_EN
    logic                 fwd_a_o;
    logic                 fwd_b_o;
`endif

    modport master (
`ifdef VCVE2_WB_FWD_EN
        input  fwd_a_o, fwd_b_o,
`endif
        output ex_valid_i, ex_addr_i, ex_data_i,
        output lsu_valid_i, lsu_addr_i, lsu_data_i,
        output sb_set_i, sb_set_addr_i,
        output raddr_a_i, raddr_b_i,
        input  ex_ready_o, lsu_ready_o,
        input  busy_a_o, busy_b_o,
        input  waddr_a_o, wdata_a_o, we_a_o
    );

    modport slave (
`ifdef VCVE2_WB_FWD_EN
        output fwd_a_o, fwd_b_o,
`endif
        input  ex_valid_i, ex_addr_i, ex_data_i,
        input  lsu_valid_i, lsu_addr_i, lsu_data_i,
        input  sb_set_i, sb_set_addr_i,
        input  raddr_a_i, raddr_b_i,
        output ex_ready_o, lsu_ready_o,
        output busy_a_o, busy_b_o,
        output waddr_a_o, wdata_a_o, we_a_o
    );
endinterface

// File: rtl/vcve2_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// vcve2_rf_wb_arbiter
//
// Purpose:
//   Drives the single register-file write port from two producers. EX
//   results go straight to the write stage; LSU load data is buffered in a
//   small FIFO. One winner per cycle is registered into waddr/wdata/we.
//   A per-register pending-load scoreboard lets decode stall on registers
//   whose loads have not been written back yet.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : vcve2_rf_wb_arbiter_if.slave (requests, scoreboard set,
//             decode lookups, register-file write port)
//
// Parameters:
//   RV32E        : 1 = 16 registers, any address with bit 4 set acts as x0
//   DataWidth    : write data width
//   LsuFifoDepth : LSU buffer entries, power of two, >= 2
//
// Optional feature (macro VCVE2_WB_FWD_EN):
//   drives bus.fwd_a_o/fwd_b_o when the write stage holds the register
//   being read, and masks busy for that register.
// ---------------------------------------------------------------------------
module vcve2_rf_wb_arbiter #(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned LsuFifoDepth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    vcve2_rf_wb_arbiter_if.slave  bus
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam int unsigned IdxW     = RV32E ? 4 : 5;
    localparam int unsigned PtrW     = $clog2(LsuFifoDepth);
    localparam int unsigned CntW     = PtrW + 1;

    // Addresses that must never be written or marked pending.
    function automatic logic f_isZero(input logic [4:0] a);
        return (a == 5'd0) || (RV32E && a[4]);
    endfunction

    logic [4:0]           r_fifoAddr [LsuFifoDepth];
    logic [DataWidth-1:0] r_fifoData [LsuFifoDepth];
    logic [PtrW-1:0]      r_wrPtr;
    logic [PtrW-1:0]      r_rdPtr;
    logic [CntW-1:0]      r_count;
    logic [NumWords-1:0]  r_pending;
    logic [NumWords-1:0]  w_pendingNext;
    logic [4:0]           r_waddr;
    logic [DataWidth-1:0] r_wdata;
    logic                 r_we;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_exWin;
    logic                 w_lsuWin;
    logic [4:0]           w_headAddr;
    logic [DataWidth-1:0] w_headData;
    logic                 w_pendA;
    logic                 w_pendB;

    assign w_full     = (r_count == CntW'(LsuFifoDepth));
    assign w_empty    = (r_count == '0);
    assign w_headAddr = r_fifoAddr[r_rdPtr];
    assign w_headData = r_fifoData[r_rdPtr];

    // A full FIFO blocks EX so load data cannot starve; otherwise EX has
    // priority and the FIFO drains only on idle EX cycles.
    assign w_exWin  = bus.ex_valid_i && !w_full;
    assign w_lsuWin = !w_empty && !w_exWin;
    assign w_push   = bus.lsu_valid_i && !w_full;

    assign bus.ex_ready_o  = !w_full;
    assign bus.lsu_ready_o = !w_full;

    // LSU FIFO: a push lands behind the head, so an entry pushed into an
    // empty FIFO only becomes poppable on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(LsuFifoDepth); i++) begin
                r_fifoAddr[i] <= '0;
                r_fifoData[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifoAddr[r_wrPtr] <= bus.lsu_addr_i;
                r_fifoData[r_wrPtr] <= bus.lsu_data_i;
                r_wrPtr             <= r_wrPtr + PtrW'(1);
            end
            if (w_lsuWin) begin
                r_rdPtr <= r_rdPtr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_lsuWin);
        end
    end

    // Write stage: x0 winners still load addr/data but suppress the enable;
    // with no winner the address/data hold for forwarding stability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_waddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_exWin) begin
            r_waddr <= bus.ex_addr_i;
            r_wdata <= bus.ex_data_i;
            r_we    <= !f_isZero(bus.ex_addr_i);
        end else if (w_lsuWin) begin
            r_waddr <= w_headAddr;
            r_wdata <= w_headData;
            r_we    <= !f_isZero(w_headAddr);
        end else begin
            r_we    <= 1'b0;
        end
    end

    // Scoreboard update: the clear is applied first so a same-cycle set of
    // the same register survives.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_lsuWin && !f_isZero(w_headAddr)) begin
            w_pendingNext[w_headAddr[IdxW-1:0]] = 1'b0;
        end
        if (bus.sb_set_i && !f_isZero(bus.sb_set_addr_i)) begin
            w_pendingNext[bus.sb_set_addr_i[IdxW-1:0]] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pendingNext;
        end
    end

    assign w_pendA = !f_isZero(bus.raddr_a_i) && r_pending[bus.raddr_a_i[IdxW-1:0]];
    assign w_pendB = !f_isZero(bus.raddr_b_i) && r_pending[bus.raddr_b_i[IdxW-1:0]];

    assign bus.waddr_a_o = r_waddr;
    assign bus.wdata_a_o = r_wdata;
    assign bus.we_a_o    = r_we;

`ifdef VCVE2_WB_FWD_EN
    logic w_fwdA;
    logic w_fwdB;

    // Decode takes wdata from the write stage, so a pending register being
    // written right now needs no stall.
    assign w_fwdA = r_we && (r_waddr == bus.raddr_a_i) && (bus.raddr_a_i != 5'd0);
    assign w_fwdB = r_we && (r_waddr == bus.raddr_b_i) && (bus.raddr_b_i != 5'd0);

    assign bus.fwd_a_o  = w_fwdA;
    assign bus.fwd_b_o  = w_fwdB;
    assign bus.busy_a_o = w_pendA && !w_fwdA;
    assign bus.busy_b_o = w_pendB && !w_fwdB;
`else
    assign bus.busy_a_o = w_pendA;
    assign bus.busy_b_o = w_pendB;
`endif

endmodule
